// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges hazard, data-memory and mul/div stalls into per-stage enables/flushes.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             btaken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  input  logic             md_start_EX,
  input  logic             md_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WD_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MD_BUSY = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            md_pend_q, md_pend_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
  logic            mem_freeze;
  logic            md_act;
  logic            run_rules;

  assign mem_freeze = mem_req_MEM & ~mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      md_pend_q <= 1'b0;
      wd_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_pend_q <= md_pend_d;
      wd_cnt_q  <= wd_cnt_d;
      err_q     <= err_d;
    end
  end

  // md_pend remembers a mul/div that must resume once the memory freeze releases
  always_comb begin
    state_d   = state_q;
    md_pend_d = md_pend_q;
    case (state_q)
      RUN: begin
        if (mem_freeze) begin
          state_d   = MEM_WAIT;
          md_pend_d = md_start_EX;
        end else if (md_start_EX) begin
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (mem_freeze) begin
          state_d   = MEM_WAIT;
          md_pend_d = 1'b1;
        end else if (md_done) begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!mem_freeze) begin
          state_d   = md_pend_q ? MD_BUSY : RUN;
          md_pend_d = 1'b0;
        end
      end
      default: begin
        state_d   = RUN;
        md_pend_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wd_cnt_d = '0;
    err_d    = err_q;
    if (state_q == MEM_WAIT) begin
      if (mem_freeze) begin
        wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
      end
      if ((MEM_TIMEOUT != 0) && (wd_cnt_q == WD_MAX)) begin
        err_d = 1'b1;
      end
    end
  end

  assign mem_timeout_err = err_q;

  assign md_act = ((state_q == RUN) && md_start_EX)
               || ((state_q == MD_BUSY) && !md_done)
               || ((state_q == MEM_WAIT) && md_pend_q);
  assign run_rules = (state_q != MD_BUSY);

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b0;
    if (rst_n && !mem_freeze) begin
      if (md_act) begin
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_en    = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        // the ID instruction is wrong-path on a taken branch, so its load-use hazard is moot
        if (run_rules && btaken_EX) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (run_rules && load_use_stall) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
